// File: rtl/kf_noise_pkg.sv
// Shared definitions for the Kalman-filter noise-matrix streamer.
//   STATE_DIM_DEF    : default process-noise (Q_k) dimension
//   MEASURE_DIM_DEF  : default measurement-noise (R_k) dimension
//   fp64_t           : IEEE-754 double carried as raw bits
//   streamer_state_e : streamer FSM state encoding
package kf_noise_pkg;

    localparam int STATE_DIM_DEF   = 12;
    localparam int MEASURE_DIM_DEF = 6;

    typedef logic [63:0] fp64_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_RDY = 3'd1,
        STREAM_Q = 3'd2,
        STREAM_R = 3'd3,
        FINISH   = 3'd4
    } streamer_state_e;

endpackage

// File: rtl/noise_idx_counter.sv
// Row/column element counter for walking a square matrix row-major.
// With TRIANGLE set only the upper triangle (col >= row) is visited, so a row
// wrap lands on the diagonal of the next row.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   clear           : force the index back to (0,0)
//   advance         : step to the next element; the final element steps to (0,0)
//   dim             : current matrix dimension
//   row, col        : current element index
//   wrap            : col is at the last column
//   last_row        : row is at the last row (wrap && last_row = final element)
module noise_idx_counter
    import kf_noise_pkg::*;
#(
    parameter int IDX_W    = 4,
    parameter bit TRIANGLE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             advance,
    input  logic [IDX_W-1:0] dim,
    output logic [IDX_W-1:0] row,
    output logic [IDX_W-1:0] col,
    output logic             wrap,
    output logic             last_row
);

    logic [IDX_W-1:0] row_q, row_d;
    logic [IDX_W-1:0] col_q, col_d;
    logic [IDX_W-1:0] dim_m1;
    logic [IDX_W-1:0] row_inc;

    assign dim_m1   = dim - IDX_W'(1);
    assign row_inc  = row_q + IDX_W'(1);
    assign wrap     = (col_q == dim_m1);
    assign last_row = (row_q == dim_m1);

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear) begin
            row_d = '0;
            col_d = '0;
        end else if (advance) begin
            if (wrap && last_row) begin
                row_d = '0;
                col_d = '0;
            end else if (wrap) begin
                row_d = row_inc;
                col_d = TRIANGLE ? row_inc : '0;
            end else begin
                col_d = col_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row = row_q;
    assign col = col_q;

endmodule

// File: rtl/noise_matrix_streamer.sv
// Streams the process-noise matrix Q_k followed by the measurement-noise
// matrix R_k as a valid/ready beat stream, one element per beat, row-major.
// Inputs are read live; upstream keeps them stable while matrices_ready=1.
// Build option: define NOISE_SYMM_ONLY_EN to emit only the upper triangle of
// each (symmetric) matrix.
// Ports:
//   clk, rst_n         : clock, synchronous active-low reset
//   start              : request a transfer (ignored while busy)
//   matrices_ready     : Q_k/R_k valid; dropping it mid-stream aborts
//   Q_k, R_k           : matrices, element [row][col] is a 64-bit double
//   m_valid, m_ready   : output handshake
//   m_data             : element value
//   m_sel              : 0 = Q_k element, 1 = R_k element
//   m_row, m_col       : element index
//   m_last             : final beat of the transfer
//   busy               : FSM not in IDLE
//   done, abort        : one-cycle completion / termination pulses
//
// state    | meaning
// IDLE     | waiting for start
// WAIT_RDY | start seen, waiting for matrices_ready
// STREAM_Q | loading Q_k elements into the output register
// STREAM_R | loading R_k elements; holds until the last beat drains
// FINISH   | last beat accepted, done pulse out
module noise_matrix_streamer
    import kf_noise_pkg::*;
#(
    parameter int STATE_DIM   = STATE_DIM_DEF,
    parameter int MEASURE_DIM = MEASURE_DIM_DEF,
    parameter int IDX_W       = $clog2(STATE_DIM)
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     start,
    input  logic                                     matrices_ready,
    input  logic [STATE_DIM-1:0][STATE_DIM-1:0][63:0]     Q_k,
    input  logic [MEASURE_DIM-1:0][MEASURE_DIM-1:0][63:0] R_k,
    output logic                                     m_valid,
    input  logic                                     m_ready,
    output logic [63:0]                              m_data,
    output logic                                     m_sel,
    output logic [IDX_W-1:0]                         m_row,
    output logic [IDX_W-1:0]                         m_col,
    output logic                                     m_last,
    output logic                                     busy,
    output logic                                     done,
    output logic                                     abort
);

    localparam int R_IDX_W = (MEASURE_DIM > 1) ? $clog2(MEASURE_DIM) : 1;

`ifdef NOISE_SYMM_ONLY_EN
    localparam bit SYMM_ONLY = 1'b1;
`else
    localparam bit SYMM_ONLY = 1'b0;
`endif

    streamer_state_e state_q, state_d;
    logic             loaded_all_q, loaded_all_d;
    logic             m_valid_q, m_valid_d;
    logic             m_last_q, m_last_d;
    logic             m_sel_q, m_sel_d;
    logic [IDX_W-1:0] m_row_q, m_row_d;
    logic [IDX_W-1:0] m_col_q, m_col_d;
    fp64_t            m_data_q, m_data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             abort_q, abort_d;

    logic             streaming;
    logic             beat_hs;
    logic             load;
    logic             in_r;
    logic             cnt_clear;
    logic [IDX_W-1:0] cnt_dim;
    logic [IDX_W-1:0] cnt_row, cnt_col;
    logic             cnt_wrap, cnt_last_row;
    logic             elem_last;
    logic [R_IDX_W-1:0] r_row, r_col;
    fp64_t            q_elem, r_elem;

    assign streaming = (state_q == STREAM_Q) || (state_q == STREAM_R);
    assign in_r      = (state_q == STREAM_R);
    assign beat_hs   = m_valid_q && m_ready;
    // The output register refills whenever it is empty or being drained this
    // cycle, which gives back-to-back beats including across the Q/R boundary.
    assign load      = streaming && matrices_ready && !loaded_all_q
                       && (!m_valid_q || m_ready);
    assign cnt_clear = (state_q == IDLE) || (state_q == WAIT_RDY);
    assign cnt_dim   = in_r ? IDX_W'(MEASURE_DIM) : IDX_W'(STATE_DIM);
    assign elem_last = cnt_wrap && cnt_last_row;

    assign r_row  = cnt_row[R_IDX_W-1:0];
    assign r_col  = cnt_col[R_IDX_W-1:0];
    assign q_elem = Q_k[cnt_row][cnt_col];
    assign r_elem = R_k[r_row][r_col];

    noise_idx_counter #(
        .IDX_W    (IDX_W),
        .TRIANGLE (SYMM_ONLY)
    ) u_idx (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (cnt_clear),
        .advance  (load),
        .dim      (cnt_dim),
        .row      (cnt_row),
        .col      (cnt_col),
        .wrap     (cnt_wrap),
        .last_row (cnt_last_row)
    );

    always_comb begin
        state_d      = state_q;
        loaded_all_d = loaded_all_q;
        m_valid_d    = m_valid_q;
        m_last_d     = m_last_q;
        m_sel_d      = m_sel_q;
        m_row_d      = m_row_q;
        m_col_d      = m_col_q;
        m_data_d     = m_data_q;
        done_d       = 1'b0;
        abort_d      = 1'b0;

        if (beat_hs) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end
        if (load) begin
            m_valid_d = 1'b1;
            m_sel_d   = in_r;
            m_row_d   = cnt_row;
            m_col_d   = cnt_col;
            m_data_d  = in_r ? r_elem : q_elem;
            m_last_d  = in_r && elem_last;
        end

        case (state_q)
            IDLE: begin
                loaded_all_d = 1'b0;
                if (start) begin
                    state_d = matrices_ready ? STREAM_Q : WAIT_RDY;
                end
            end
            WAIT_RDY: begin
                if (matrices_ready) begin
                    state_d = STREAM_Q;
                end
            end
            STREAM_Q, STREAM_R: begin
                // A completed final beat wins over a simultaneous ready drop.
                if (beat_hs && m_last_q) begin
                    state_d = FINISH;
                    done_d  = 1'b1;
                end else if (!matrices_ready) begin
                    state_d   = IDLE;
                    abort_d   = 1'b1;
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                end else if (load && elem_last) begin
                    if (in_r) begin
                        loaded_all_d = 1'b1;
                    end else begin
                        state_d = STREAM_R;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            loaded_all_q <= 1'b0;
            m_valid_q    <= 1'b0;
            m_last_q     <= 1'b0;
            m_sel_q      <= 1'b0;
            m_row_q      <= '0;
            m_col_q      <= '0;
            m_data_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            loaded_all_q <= loaded_all_d;
            m_valid_q    <= m_valid_d;
            m_last_q     <= m_last_d;
            m_sel_q      <= m_sel_d;
            m_row_q      <= m_row_d;
            m_col_q      <= m_col_d;
            m_data_q     <= m_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            abort_q      <= abort_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_last  = m_last_q;
    assign m_sel   = m_sel_q;
    assign m_row   = m_row_q;
    assign m_col   = m_col_q;
    assign m_data  = m_data_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign abort   = abort_q;

endmodule

// File: doc/noise_matrix_streamer.md
NOISE_MATRIX_STREAMER -- requirements
Module: noise_matrix_streamer

Interface
REQ-001 The block SHALL have parameter STATE_DIM, default 12: Q_k dimension.
REQ-002 The block SHALL have parameter MEASURE_DIM, default 6: R_k dimension.
REQ-003 The block SHALL have parameter IDX_W, default $clog2(STATE_DIM) (=4): width of the row/column index.
REQ-004 The block SHALL have port clk, input, 1 bit: clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-006 The block SHALL have port start, input, 1 bit: request to stream both noise matrices.
REQ-007 The block SHALL have port matrices_ready, input, 1 bit: upstream Q_k/R_k valid and stable.
REQ-008 The block SHALL have port Q_k, input, 64 x STATE_DIM x STATE_DIM: IEEE-754 double process-noise matrix.
REQ-009 The block SHALL have port R_k, input, 64 x MEASURE_DIM x MEASURE_DIM: IEEE-754 double measurement-noise matrix.
REQ-010 The block SHALL have port m_valid, output, 1 bit: output beat valid.
REQ-011 The block SHALL have port m_ready, input, 1 bit: downstream accepts the beat.
REQ-012 The block SHALL have port m_data, output, 64 bits: element value.
REQ-013 The block SHALL have port m_sel, output, 1 bit: 0 = Q_k element, 1 = R_k element.
REQ-014 The block SHALL have port m_row / m_col, output, IDX_W each: element indices.
REQ-015 The block SHALL have port m_last, output, 1 bit: final beat of the transfer.
REQ-016 The block SHALL have port busy, output, 1 bit: high in every state other than IDLE.
REQ-017 The block SHALL have ports done / abort, output, 1 bit each: single-cycle completion / termination pulses.

Function
REQ-018 The FSM SHALL have the states IDLE, WAIT_RDY, STREAM_Q, STREAM_R, FINISH.
REQ-019 IDLE SHALL transition as follows on start=1: to STREAM_Q if matrices_ready=1, else to WAIT_RDY.
REQ-020 WAIT_RDY SHALL go to STREAM_Q in the first cycle in which matrices_ready=1.
REQ-021 Element order SHALL be all of Q_k row-major, then all of R_k row-major, starting at index (0,0).
REQ-022 All outputs SHALL be registered, and m_valid SHALL rise in the cycle after entry to STREAM_Q.
REQ-023 A beat SHALL transfer only on m_valid && m_ready.
REQ-024 m_data, m_sel, m_row, m_col and m_last SHALL hold stable while m_valid && !m_ready.
REQ-025 With m_ready held at 1, the block SHALL sustain 1 beat per cycle with no bubble at the Q-to-R boundary: 144 Q beats then 36 R beats, 180 total.
REQ-026 Column wrap: col==dim-1 SHALL set col to 0 and increment row; the last element of Q SHALL move to R (0,0).
REQ-027 m_last SHALL be 1 only with R(MEASURE_DIM-1, MEASURE_DIM-1).
REQ-028 After the m_last handshake, the FSM SHALL go to FINISH with m_valid=0, pulse done for one cycle, and return to IDLE on the next cycle.
REQ-029 start SHALL be ignored while busy=1.
REQ-030 If matrices_ready=0 in STREAM_Q or STREAM_R, the block SHALL clear m_valid next cycle, pulse abort for one cycle and go to IDLE; a beat handshaken in that same cycle SHALL count as delivered.
REQ-031 If start=1 and matrices_ready falls in the same cycle, the block SHALL go to WAIT_RDY without an abort.
REQ-032 Q_k/R_k SHALL be read live (no snapshot); upstream holds them stable while matrices_ready=1.

Reset
REQ-033 When rst_n=0 at a clock edge, the FSM SHALL go to IDLE and m_valid, m_last, busy, done, abort, m_sel, m_row, m_col and m_data SHALL all become 0.
REQ-034 Reset mid-stream SHALL discard the transfer with no done or abort pulse.

Configuration
REQ-035 With macro NOISE_SYMM_ONLY_EN defined, only the upper triangle (col >= row) SHALL be emitted: 78 Q beats plus 21 R beats = 99, and a row wrap SHALL restart at col = row+1.
REQ-036 With NOISE_SYMM_ONLY_EN undefined, full matrices SHALL be emitted per REQ-025.

Structure
REQ-037 Package kf_noise_pkg SHALL hold STATE_DIM_DEF, MEASURE_DIM_DEF, the fp64_t typedef (logic [63:0]) and the streamer state enum.
REQ-038 The block SHALL contain one sub-module, noise_idx_counter, a row/col counter with dim input and triangle option, producing wrap and end flags.

Verification
REQ-039 The bench SHALL drive Q[i][j]=i*16+j and R[i][j]=0x100+i*16+j, with matrices_ready=1, start pulse and m_ready=1 -> 180 beats in consecutive cycles; beat 145 SHALL be sel=1 with data 0x100; beat 180 SHALL carry m_last; done SHALL pulse 1 cycle later.
REQ-040 The bench SHALL toggle m_ready 1-0-1-0 -> no beat lost or duplicated, and outputs stable during stalls.
REQ-041 The bench SHALL issue start while matrices_ready=0 and raise it 5 cycles later -> WAIT_RDY held, then the first beat (0,0) SHALL appear.
REQ-042 The bench SHALL drop matrices_ready after beat 50 -> abort pulse, m_valid low, and no done pulse.
REQ-043 The bench SHALL assert rst_n=0 at beat 100 -> all outputs 0 next cycle, and a following start SHALL restart at Q(0,0).
REQ-044 The bench SHALL rerun REQ-039 with NOISE_SYMM_ONLY_EN defined -> 99 beats, the second beat SHALL be (0,1) and the 13th SHALL be (1,1).
